axi_mem_port_arb: RTL and testbench

AXI_MEM_PORT_ARB -- requirements
Module: axi_mem_port_arb

---
 rtl/axi_mem_port_arb.sv | 106 ++++++++++
 tb/tb_axi_mem_port_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_port_arb.sv
// Two-way arbiter muxing a write controller and a read controller onto one single-port SRAM.
// Define AXI_MEM_ARB_RR_EN for round-robin arbitration; the default build is fixed write priority.
module axi_mem_port_arb #(
  parameter int unsigned MEM_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUMBYTES       = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid_i,
  output logic                      wr_grant_o,
  input  logic                      wr_cen_i,
  input  logic                      wr_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_a_i,
  input  logic [DATA_WIDTH-1:0]     wr_d_i,
  input  logic [NUMBYTES-1:0]       wr_be_i,
  input  logic                      rd_valid_i,
  output logic                      rd_grant_o,
  input  logic                      rd_cen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_a_i,
  output logic [DATA_WIDTH-1:0]     rd_q_o,
  output logic                      rd_rvalid_o,
  output logic                      mem_cen_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0]     mem_d_o,
  output logic [NUMBYTES-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_q_i
);

  logic                  wr_win_c;
  logic                  rd_issue_c;
  logic [DATA_WIDTH-1:0] q_hold;

  // The write port always drives a write cycle, so its own WEN is not needed.
  logic                  unused_wr_wen;
  assign unused_wr_wen = wr_wen_i;

`ifdef AXI_MEM_ARB_RR_EN
  logic wr_issue_c;
  logic last_wr;

  assign wr_issue_c = wr_grant_o & ~wr_cen_i;

  // Last-served flop; moves only when an access actually reaches the SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b1;
    end else if (wr_issue_c) begin
      last_wr <= 1'b1;
    end else if (rd_issue_c) begin
      last_wr <= 1'b0;
    end
  end

  assign wr_win_c = ~last_wr;
`else
  assign wr_win_c = 1'b1;
`endif

  // Conflict resolution: write wins only when wr_win_c says so.
  assign wr_grant_o = wr_valid_i & (~rd_valid_i | wr_win_c);
  assign rd_grant_o = rd_valid_i & ~wr_grant_o;
  assign rd_issue_c = rd_grant_o & ~rd_cen_i;

  // SRAM port mux; idle state parks the macro deselected with zeroed buses.
  always_comb begin
    mem_cen_o = 1'b1;
    mem_wen_o = 1'b1;
    mem_a_o   = '0;
    mem_d_o   = '0;
    mem_be_o  = '0;
    if (wr_grant_o) begin
      mem_cen_o = wr_cen_i;
      mem_wen_o = 1'b0;
      mem_a_o   = wr_a_i;
      mem_d_o   = wr_d_i;
      mem_be_o  = wr_be_i;
    end else if (rd_grant_o) begin
      mem_cen_o = rd_cen_i;
      mem_wen_o = 1'b1;
      mem_a_o   = rd_a_i;
      mem_be_o  = '1;
    end
  end

  // Read data arrives one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rvalid_o <= 1'b0;
    end else begin
      rd_rvalid_o <= rd_issue_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_hold <= '0;
    end else if (rd_rvalid_o) begin
      q_hold <= mem_q_i;
    end
  end

  assign rd_q_o = rd_rvalid_o ? mem_q_i : q_hold;

endmodule

// File: tb/tb_axi_mem_port_arb.sv
// Directed bench for axi_mem_port_arb with an SRAM model and a read-response scoreboard.
`timescale 1ns/1ps
module tb_axi_mem_port_arb;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid_i, wr_cen_i, wr_wen_i;
  logic [AW-1:0] wr_a_i;
  logic [DW-1:0] wr_d_i;
  logic [BW-1:0] wr_be_i;
  logic          rd_valid_i, rd_cen_i;
  logic [AW-1:0] rd_a_i;
  logic          wr_grant_o, rd_grant_o, rd_rvalid_o;
  logic [DW-1:0] rd_q_o;
  logic          mem_cen_o, mem_wen_o;
  logic [AW-1:0] mem_a_o;
  logic [DW-1:0] mem_d_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_q_i;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sram [0:255];

  axi_mem_port_arb #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBYTES(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_grant_o(wr_grant_o), .wr_cen_i(wr_cen_i),
    .wr_wen_i(wr_wen_i), .wr_a_i(wr_a_i), .wr_d_i(wr_d_i), .wr_be_i(wr_be_i),
    .rd_valid_i(rd_valid_i), .rd_grant_o(rd_grant_o), .rd_cen_i(rd_cen_i),
    .rd_a_i(rd_a_i), .rd_q_o(rd_q_o), .rd_rvalid_o(rd_rvalid_o),
    .mem_cen_o(mem_cen_o), .mem_wen_o(mem_wen_o), .mem_a_o(mem_a_o),
    .mem_d_o(mem_d_o), .mem_be_o(mem_be_o), .mem_q_i(mem_q_i)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: active-low CEN/WEN, byte enables, one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_cen_o) begin
      if (!mem_wen_o) begin
        for (int b = 0; b < int'(BW); b++)
          if (mem_be_o[b]) sram[mem_a_o[7:0]][b*8 +: 8] <= mem_d_o[b*8 +: 8];
      end else begin
        mem_q_i <= sram[mem_a_o[7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rd_rvalid_o) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rd_rvalid_o), 64'd0);
      else chk("rsp_data", rd_q_o, exp_q.pop_front());
    end
  end

  task automatic drv_wr(input logic v, input logic cen, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    wr_valid_i = v; wr_cen_i = cen; wr_a_i = a; wr_d_i = d; wr_be_i = be;
  endtask

  task automatic drv_rd(input logic v, input logic cen, input logic [AW-1:0] a);
    rd_valid_i = v; rd_cen_i = cen; rd_a_i = a;
  endtask

  task automatic idle();
    drv_wr(1'b0, 1'b1, '0, '0, '0);
    drv_rd(1'b0, 1'b1, '0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grants(input string tag, input logic w, input logic r);
    chk({tag, "_wr_grant"}, 64'(wr_grant_o), 64'(w));
    chk({tag, "_rd_grant"}, 64'(rd_grant_o), 64'(r));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    mem_q_i = '0;
    wr_wen_i = 1'b0;
    idle();
    rst_n = 1'b0;

    // Reset and idle
    @(negedge clk);
    chk_grants("rst", 1'b0, 1'b0);
    chk("rst_cen", 64'(mem_cen_o), 64'd1);
    chk("rst_wen", 64'(mem_wen_o), 64'd1);
    chk("rst_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk("rst_q", rd_q_o, 64'd0);
    #2 rst_n = 1'b1;
    next_cyc();
    @(negedge clk);
    chk_grants("idle", 1'b0, 1'b0);
    chk("idle_cen", 64'(mem_cen_o), 64'd1);
    chk("idle_a", 64'(mem_a_o), 64'd0);
    next_cyc();

    // Lone write
    drv_wr(1'b1, 1'b0, 13'h10, 64'hA5A5, 8'hFF);
    @(negedge clk);
    chk_grants("wr", 1'b1, 1'b0);
    chk("wr_cen", 64'(mem_cen_o), 64'd0);
    chk("wr_wen", 64'(mem_wen_o), 64'd0);
    chk("wr_a", 64'(mem_a_o), 64'h10);
    chk("wr_d", mem_d_o, 64'hA5A5);
    chk("wr_be", 64'(mem_be_o), 64'hFF);
    next_cyc();

    // Lone read of the same word
    idle();
    drv_rd(1'b1, 1'b0, 13'h10);
    exp_q.push_back(64'hA5A5);
    @(negedge clk);
    chk_grants("rd", 1'b0, 1'b1);
    chk("rd_wen", 64'(mem_wen_o), 64'd1);
    chk("rd_a", 64'(mem_a_o), 64'h10);
    chk("rd_be", 64'(mem_be_o), 64'hFF);
    chk("rd_d", mem_d_o, 64'd0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("rd_rvalid_1", 64'(rd_rvalid_o), 64'd1);
    next_cyc();
    @(negedge clk);
    chk("rd_rvalid_0", 64'(rd_rvalid_o), 64'd0);
    chk("rd_hold", rd_q_o, 64'hA5A5);
    next_cyc();

    // Partial byte-enable write merges into existing word
    drv_wr(1'b1, 1'b0, 13'h20, 64'h1111111111111111, 8'hFF);
    next_cyc();
    drv_wr(1'b1, 1'b0, 13'h20, 64'h2222222222222222, 8'h0F);
    next_cyc();
    idle();
    drv_rd(1'b1, 1'b0, 13'h20);
    exp_q.push_back(64'h1111111122222222);
    next_cyc();
    idle();
    // Granted but CEN high: nothing issued
    drv_wr(1'b1, 1'b1, 13'h20, 64'hDEAD, 8'hFF);
    @(negedge clk);
    chk_grants("cenhi", 1'b1, 1'b0);
    chk("cenhi_cen", 64'(mem_cen_o), 64'd1);
    next_cyc();
    idle();
    next_cyc();

    // Conflict sequence from a fresh reset
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drv_wr(1'b1, 1'b0, 13'h30, 64'h3333, 8'hFF);
    drv_rd(1'b1, 1'b0, 13'h10);
    for (int c = 0; c < 4; c++) begin
`ifdef AXI_MEM_ARB_RR_EN
      if (c % 2 == 0) exp_q.push_back(64'hA5A5);
      @(negedge clk);
      chk_grants($sformatf("rr%0d", c), (c % 2 == 1), (c % 2 == 0));
`else
      @(negedge clk);
      chk_grants($sformatf("fix%0d", c), 1'b1, 1'b0);
      chk($sformatf("fix%0d_rvalid", c), 64'(rd_rvalid_o), 64'd0);
`endif
      next_cyc();
    end

    // Conflict where the winner is not issued must not move priority
    drv_rd(1'b1, 1'b1, 13'h10);
    @(negedge clk);
`ifdef AXI_MEM_ARB_RR_EN
    chk_grants("noiss", 1'b0, 1'b1);
`else
    chk_grants("noiss", 1'b1, 1'b0);
    chk("noiss_rvalid", 64'(rd_rvalid_o), 64'd0);
`endif
    next_cyc();
    drv_rd(1'b1, 1'b0, 13'h10);
`ifdef AXI_MEM_ARB_RR_EN
    exp_q.push_back(64'hA5A5);
    @(negedge clk);
    chk_grants("after_noiss", 1'b0, 1'b1);
`else
    @(negedge clk);
    chk_grants("after_noiss", 1'b1, 1'b0);
`endif
    next_cyc();
    idle();
    next_cyc();

    // Read then write next cycle: response survives, write lands
    drv_rd(1'b1, 1'b0, 13'h30);
    exp_q.push_back(64'h3333);
    next_cyc();
    idle();
    drv_wr(1'b1, 1'b0, 13'h40, 64'h4444, 8'hFF);
    @(negedge clk);
    chk_grants("rw", 1'b1, 1'b0);
    chk("rw_rvalid", 64'(rd_rvalid_o), 64'd1);
    chk("rw_q", rd_q_o, 64'h3333);
    next_cyc();
    idle();
    drv_rd(1'b1, 1'b0, 13'h40);
    exp_q.push_back(64'h4444);
    next_cyc();
    idle();
    next_cyc();

    // Reset while a read response is pending drops it
    drv_rd(1'b1, 1'b0, 13'h10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle();
    #1;
    chk("rstfl_rvalid_lo", 64'(rd_rvalid_o), 64'd0);
    chk("rstfl_q_lo", rd_q_o, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstfl_rvalid", 64'(rd_rvalid_o), 64'd0);
    chk_grants("rstfl", 1'b0, 1'b0);
    next_cyc();
    @(negedge clk);
    chk("rstfl_rvalid2", 64'(rd_rvalid_o), 64'd0);
    chk("rstfl_q", rd_q_o, 64'd0);
    next_cyc();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    chk("timeout", 64'd1, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "FAIL timeout");
  end

endmodule
